// File: rtl/conv_out_writer.sv
// Output stage after the conv MAC array: bias, round, ReLU, saturate,
// then sequential writes into the output feature RAM.
module conv_out_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 8,
  parameter int OUT_W      = 24,
  parameter int OUT_H      = 24,
  parameter int NUM_MAPS   = 1,
  parameter int ADDR_WIDTH = 10,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  accum_sload,
  input  logic [ACC_WIDTH-1:0]  acc_result,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  out_wren,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int TOTAL = OUT_W * OUT_H * NUM_MAPS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int SW    = ACC_WIDTH + 2;
  localparam int HB    = SW - DATA_WIDTH + 1;

  localparam logic signed [SW-1:0] MAXV =
    {{HB{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{HB{1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] RND =
    {{(SW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           launch_cnt;
  logic [ADDR_WIDTH-1:0]   wr_cnt;
  logic                    s1_v;
  logic signed [SW-1:0]    s1;
  logic signed [SW-1:0]    acc_x;
  logic signed [SW-1:0]    bias_x;
  logic signed [SW-1:0]    r;
  logic                    launch;
  logic                    clamp;
  logic                    hi;
  logic                    lo;
  logic [DATA_WIDTH-1:0]   res;

  assign launch = (state == RUN) && accum_sload
                  && (launch_cnt < CW'(TOTAL));

  assign acc_x  = {{2{acc_result[ACC_WIDTH-1]}}, acc_result};
  assign bias_x = {{(SW-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}},
                   bias, {FRAC_BITS{1'b0}}};

  // Arithmetic shift after adding half an LSB gives round-half-up.
  assign r     = s1 >>> FRAC_BITS;
  assign clamp = RELU_EN && r[SW-1];
  assign hi    = r > MAXV;
  assign lo    = (r < MINV) && !clamp;

  always_comb begin
    res = r[DATA_WIDTH-1:0];
    unique case (1'b1)
      clamp:   res = '0;
      hi:      res = MAXV[DATA_WIDTH-1:0];
      lo:      res = MINV[DATA_WIDTH-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      launch_cnt <= '0;
      wr_cnt     <= '0;
      s1_v       <= 1'b0;
      s1         <= '0;
      out_wren   <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      s1_v     <= launch;
      out_wren <= s1_v;
      if (launch) begin
        s1         <= acc_x + bias_x + RND;
        launch_cnt <= launch_cnt + CW'(1);
      end
      if (s1_v) begin
        out_data <= res;
        out_addr <= wr_cnt;
        wr_cnt   <= wr_cnt + ADDR_WIDTH'(1);
        if (hi || lo) ovf <= 1'b1;
      end
      unique case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (launch && launch_cnt == CW'(TOTAL - 1)) begin
          state <= DRAIN;
          busy  <= 1'b0;
        end
        // Last pixel is in stage 2 once stage 1 is empty.
        DRAIN: if (!s1_v) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_writer.sv
// Directed bench for conv_out_writer: a ReLU and a non-ReLU
// instance share stimulus on a 2x2 output map.
module tb_conv_out_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        accum_sload;
  logic [39:0] acc_result;
  logic [15:0] bias;

  logic        w1, b1, d1, v1;
  logic [9:0]  a1;
  logic [15:0] q1;
  logic        w2, b2, d2, v2;
  logic [9:0]  a2;
  logic [15:0] q2;

  logic [29:0] o1, o2;
  assign o1 = {w1, a1, q1, b1, d1, v1};
  assign o2 = {w2, a2, q2, b2, d2, v2};

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  conv_out_writer #(
    .OUT_W(2), .OUT_H(2), .NUM_MAPS(1), .RELU_EN(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .accum_sload(accum_sload), .acc_result(acc_result),
    .bias(bias), .out_wren(w1), .out_addr(a1),
    .out_data(q1), .busy(b1), .done(d1), .ovf(v1)
  );

  conv_out_writer #(
    .OUT_W(2), .OUT_H(2), .NUM_MAPS(1), .RELU_EN(1'b0)
  ) dut_nr (
    .clock(clock), .reset(reset), .start(start),
    .accum_sload(accum_sload), .acc_result(acc_result),
    .bias(bias), .out_wren(w2), .out_addr(a2),
    .out_data(q2), .busy(b2), .done(d2), .ovf(v2)
  );

  function automatic logic [29:0] pk(
    input logic w, input logic [9:0] a, input logic [15:0] d,
    input logic b, input logic dn, input logic v);
    return {w, a, d, b, dn, v};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    start = 1'b0;
    accum_sload = 1'b0;
    acc_result = '0;
    bias = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [39:0] acc,
                        input logic [15:0] bs);
    accum_sload = 1'b1;
    acc_result = acc;
    bias = bs;
    tick();
    accum_sload = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    logic [29:0] e;
    e = '0;
    start = 1'b0;
    accum_sload = 1'b0;
    acc_result = '0;
    bias = '0;
    reset = 1'b1;
    #2;
    vecs++;
    if (o1 !== e) begin
      errs++;
      $display("FAIL reset_relu got %h want %h", o1, e);
    end
    vecs++;
    if (o2 !== e) begin
      errs++;
      $display("FAIL reset_norelu got %h want %h", o2, e);
    end
    tick();
    reset = 1'b0;
    tick();
    vecs++;
    if (o1 !== e) begin
      errs++;
      $display("FAIL post_reset got %h want %h", o1, e);
    end
  endtask

  task automatic test_basic;
    logic [29:0] e;
    do_reset();
    start = 1'b1;
    tick();
    strobe(40'd768, 16'd2);
    e = pk(1'b1, 10'd0, 16'h0005, 1'b1, 1'b0, 1'b0);
    vecs++;
    if (o1 !== e) begin
      errs++;
      $display("FAIL basic_relu got %h want %h", o1, e);
    end
    vecs++;
    if (o2 !== e) begin
      errs++;
      $display("FAIL basic_norelu got %h want %h", o2, e);
    end
  endtask

  task automatic test_relu;
    logic [29:0] e1, e2;
    strobe(-40'sd1024, 16'd0);
    e1 = pk(1'b1, 10'd1, 16'h0000, 1'b1, 1'b0, 1'b0);
    e2 = pk(1'b1, 10'd1, 16'hFFFC, 1'b1, 1'b0, 1'b0);
    vecs++;
    if (o1 !== e1) begin
      errs++;
      $display("FAIL relu_clamp got %h want %h", o1, e1);
    end
    vecs++;
    if (o2 !== e2) begin
      errs++;
      $display("FAIL relu_off got %h want %h", o2, e2);
    end
  endtask

  task automatic test_saturate;
    logic [29:0] e1, e2;
    strobe(40'h01_0000_0000, 16'd0);
    e1 = pk(1'b1, 10'd2, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    vecs++;
    if (o1 !== e1) begin
      errs++;
      $display("FAIL sat_hi_relu got %h want %h", o1, e1);
    end
    vecs++;
    if (o2 !== e1) begin
      errs++;
      $display("FAIL sat_hi_norelu got %h want %h", o2, e1);
    end
    strobe(40'hFF_0000_0000, 16'd0);
    e1 = pk(1'b1, 10'd3, 16'h0000, 1'b0, 1'b0, 1'b1);
    e2 = pk(1'b1, 10'd3, 16'h8000, 1'b0, 1'b0, 1'b1);
    vecs++;
    if (o1 !== e1) begin
      errs++;
      $display("FAIL sat_lo_relu got %h want %h", o1, e1);
    end
    vecs++;
    if (o2 !== e2) begin
      errs++;
      $display("FAIL sat_lo_norelu got %h want %h", o2, e2);
    end
    tick();
    e1 = pk(1'b0, 10'd3, 16'h0000, 1'b0, 1'b1, 1'b1);
    e2 = pk(1'b0, 10'd3, 16'h8000, 1'b0, 1'b1, 1'b1);
    vecs++;
    if (o1 !== e1) begin
      errs++;
      $display("FAIL done_relu got %h want %h", o1, e1);
    end
    vecs++;
    if (o2 !== e2) begin
      errs++;
      $display("FAIL done_norelu got %h want %h", o2, e2);
    end
  endtask

  task automatic test_back_to_back;
    logic [29:0] e;
    logic        w;
    logic [9:0]  a;
    logic [15:0] d;
    do_reset();
    start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      accum_sload = (i < 6);
      acc_result = 40'((i + 1) * 256);
      bias = '0;
      tick();
      w = (i >= 1) && (i <= 4);
      a = (i < 1) ? 10'd0 : (i <= 4) ? 10'(i - 1) : 10'd3;
      d = (i < 1) ? 16'd0 : (i <= 4) ? 16'(i) : 16'd4;
      e = pk(w, a, d, (i < 3), (i >= 5), 1'b0);
      vecs++;
      if (o1 !== e) begin
        errs++;
        $display("FAIL b2b_relu step %0d got %h want %h", i, o1, e);
      end
      vecs++;
      if (o2 !== e) begin
        errs++;
        $display("FAIL b2b_norelu step %0d got %h want %h", i, o2, e);
      end
    end
    accum_sload = 1'b0;
  endtask

  task automatic test_idle_ignore;
    logic [29:0] e;
    do_reset();
    e = '0;
    for (int i = 0; i < 3; i++) begin
      accum_sload = 1'b1;
      acc_result = 40'd768;
      bias = 16'd2;
      tick();
      accum_sload = 1'b0;
      tick();
      vecs++;
      if (o1 !== e) begin
        errs++;
        $display("FAIL idle_relu step %0d got %h want %h", i, o1, e);
      end
      vecs++;
      if (o2 !== e) begin
        errs++;
        $display("FAIL idle_norelu step %0d got %h want %h", i, o2, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [29:0] e1, e2;
    do_reset();
    start = 1'b1;
    tick();
    accum_sload = 1'b1;
    acc_result = 40'd768;
    bias = 16'd2;
    tick();
    accum_sload = 1'b0;
    reset = 1'b1;
    #1;
    e1 = '0;
    vecs++;
    if (o1 !== e1) begin
      errs++;
      $display("FAIL midrst_clear got %h want %h", o1, e1);
    end
    start = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (o1 !== e1) begin
        errs++;
        $display("FAIL midrst_nowrite step %0d got %h want %h", i, o1, e1);
      end
    end
    start = 1'b1;
    tick();
    strobe(40'hFF_0000_0000, 16'd0);
    e1 = pk(1'b1, 10'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    e2 = pk(1'b1, 10'd0, 16'h8000, 1'b1, 1'b0, 1'b1);
    vecs++;
    if (o1 !== e1) begin
      errs++;
      $display("FAIL restart_relu got %h want %h", o1, e1);
    end
    vecs++;
    if (o2 !== e2) begin
      errs++;
      $display("FAIL restart_norelu got %h want %h", o2, e2);
    end
    strobe(40'd768, 16'd2);
    e1 = pk(1'b1, 10'd1, 16'h0005, 1'b1, 1'b0, 1'b0);
    e2 = pk(1'b1, 10'd1, 16'h0005, 1'b1, 1'b0, 1'b1);
    vecs++;
    if (o1 !== e1) begin
      errs++;
      $display("FAIL restart2_relu got %h want %h", o1, e1);
    end
    vecs++;
    if (o2 !== e2) begin
      errs++;
      $display("FAIL restart2_norelu got %h want %h", o2, e2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturate();
    test_back_to_back();
    test_idle_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/conv_out_writer.md
Name: conv_out_writer

Overview:
Sits directly downstream of the convolution controller and its MAC array. On every accumulator-reload strobe it captures the finished accumulator sum for one output pixel. It adds bias, rounds, applies optional ReLU and saturates the result to DATA_WIDTH. It then writes the result to the output feature RAM at sequential addresses and flags completion after the last pixel.

Parameters:
DATA_WIDTH, 16, output/bias word width (signed)
ACC_WIDTH, 40, accumulator result width (signed)
FRAC_BITS, 8, fractional bits of data/bias; acc_result carries 2*FRAC_BITS
OUT_W, 24, output feature map width
OUT_H, 24, output feature map height
NUM_MAPS, 1, output maps produced per pass (NUM_ONEMULT)
ADDR_WIDTH, 10, output RAM address width; must satisfy 2^ADDR_WIDTH >= OUT_W*OUT_H*NUM_MAPS
RELU_EN, 1, 1 = clamp negatives to 0

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  level from controller; first valid accumulator result follows
accum_sload  in  1  one-cycle strobe; acc_result valid this cycle
acc_result  in  ACC_WIDTH  signed completed MAC sum
bias  in  DATA_WIDTH  signed bias for current map, Q.FRAC_BITS
out_wren  out  1  output RAM write enable, one-cycle pulse
out_addr  out  ADDR_WIDTH  output RAM write address
out_data  out  DATA_WIDTH  output RAM write data
busy  out  1  high in RUN state
done  out  1  sticky, all pixels written
ovf  out  1  sticky, any result saturated

Behaviour:
- Reset (async): state=IDLE. out_wren=0, out_addr=0, out_data=0, busy=0, done=0, ovf=0. Pipeline valids and write counter are cleared.
- TOTAL = OUT_W*OUT_H*NUM_MAPS.
- FSM states:
  - IDLE: moves to RUN when start=1. accum_sload is ignored in IDLE.
  - RUN: busy=1. Each cycle with accum_sload=1 launches one pixel into the pipeline.
  - DRAIN: entered the cycle after the TOTAL-th launch. Waits for the pipeline to empty, then moves to DONE.
  - DONE: done=1, busy=0. Stays in DONE until reset. accum_sload and start are ignored.
- Pipeline stage 1 (registered): s1 = sext(acc_result, ACC_WIDTH+2) + (sext(bias) << FRAC_BITS) + 2^(FRAC_BITS-1).
- Pipeline stage 2 (registered):
  - r = s1 >>> FRAC_BITS (arithmetic shift, i.e. round-half-up).
  - If RELU_EN and r<0, then 0.
  - Else if r > 2^(DATA_WIDTH-1)-1, then 0x7FFF-equivalent and set ovf.
  - Else if r < -2^(DATA_WIDTH-1), then min value and set ovf.
  - Otherwise r truncated to DATA_WIDTH.
  - out_data is driven from this stage.
- Latency: accum_sload in cycle N produces out_wren=1 in cycle N+2, with out_data and out_addr valid in the same cycle.
- Address handling:
  - out_addr for write k is k (0..TOTAL-1), map-major order as the controller emits.
  - The address counter increments after each write.
  - out_addr holds its last value when no write occurs.
- Back-to-back strobes (accum_sload every cycle) are fully pipelined, giving one write per cycle.
- Launches beyond TOTAL are dropped. The launch counter saturates, and no extra writes or address wrap occur.
- done asserts the cycle after the TOTAL-th write, i.e. the DRAIN to DONE transition.
- start deassert during RUN has no effect; the pass completes.
- Reset mid-operation: all state is cleared immediately. Any in-flight pipeline data is discarded and no write is issued.
- ovf clamp rule: ReLU clamping does not set ovf.

Test Plan:
- FRAC_BITS=8, start=1, accum_sload with acc_result=768, bias=2 -> two cycles later out_wren=1, out_addr=0, out_data=0x0005, ovf=0.
- acc_result=-1024, bias=0, RELU_EN=1 -> out_data=0x0000, ovf=0. With RELU_EN=0 -> out_data=0xFFFC.
- acc_result=0x01_0000_0000, bias=0 -> out_data=0x7FFF, ovf=1, and ovf stays 1 through all later writes. With RELU_EN=0, acc_result=-(2^32) -> out_data=0x8000.
- OUT_W=OUT_H=2, NUM_MAPS=1, accum_sload every cycle for 6 cycles -> exactly 4 writes at addresses 0,1,2,3 on consecutive cycles. done=1 one cycle after the last write; 5th and 6th strobes produce no write.
- accum_sload pulses before start=1 -> no writes, out_addr stays 0, busy=0.
- Assert reset one cycle after a strobe in RUN -> no out_wren follows. All outputs return to 0. The next pass after start restarts at out_addr=0.
